// File: rtl/mem_wb_writeback_if.sv
// MEM/WB stage bus: MEM-side inputs and pipeline control, register file write
// port, and the WB->EX forwarding request/response signals.
interface mem_wb_writeback_if;
  logic        Stall;
  logic        Flush;
  logic        Mem_Valid;
  logic        Mem_Reg_Write;
  logic        Mem_Mem_To_Reg;
  logic        Mem_Link;
  logic [4:0]  Mem_Write_Reg;
  logic [31:0] Mem_ALU_Result;
  logic [31:0] Mem_Read_Data;
  logic [31:0] Mem_PC_Plus4;
  logic        Reg_Write;
  logic [4:0]  Write_Reg;
  logic [31:0] Write_Dat;
  logic [4:0]  Fwd_Reg1;
  logic [4:0]  Fwd_Reg2;
  logic        Fwd_Hit1;
  logic        Fwd_Hit2;
  logic [31:0] Fwd_Dat1;
  logic [31:0] Fwd_Dat2;

  modport master (
    output Stall, Flush, Mem_Valid, Mem_Reg_Write, Mem_Mem_To_Reg, Mem_Link,
           Mem_Write_Reg, Mem_ALU_Result, Mem_Read_Data, Mem_PC_Plus4,
           Fwd_Reg1, Fwd_Reg2,
    input  Reg_Write, Write_Reg, Write_Dat, Fwd_Hit1, Fwd_Hit2, Fwd_Dat1, Fwd_Dat2
  );

  modport slave (
    input  Stall, Flush, Mem_Valid, Mem_Reg_Write, Mem_Mem_To_Reg, Mem_Link,
           Mem_Write_Reg, Mem_ALU_Result, Mem_Read_Data, Mem_PC_Plus4,
           Fwd_Reg1, Fwd_Reg2,
    output Reg_Write, Write_Reg, Write_Dat, Fwd_Hit1, Fwd_Hit2, Fwd_Dat1, Fwd_Dat2
  );
endinterface

// File: rtl/mem_wb_writeback.sv
// MEM/WB pipeline register, writeback driver and retired-write counter.
// Define WB_FWD_EN to build the WB->EX forwarding comparators.
module mem_wb_writeback #(
  parameter int RETIRE_W = 32
) (
  input  logic                Clk,
  input  logic                Rst,
  mem_wb_writeback_if.slave   Bus,
  output logic [RETIRE_W-1:0] Retire_Count
);

  logic        wb_valid;
  logic        wb_reg_write;
  logic        wb_mem_to_reg;
  logic        wb_link;
  logic [4:0]  wb_dest;
  logic [31:0] wb_alu;
  logic [31:0] wb_rdata;
  logic [31:0] wb_pc4;
  logic        wb_committed;

  logic [4:0]  eff_dest;
  logic [31:0] eff_dat;
  logic        wr_en;
  logic        dest_live;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      wb_valid      <= 1'b0;
      wb_reg_write  <= 1'b0;
      wb_mem_to_reg <= 1'b0;
      wb_link       <= 1'b0;
      wb_dest       <= 5'd0;
      wb_alu        <= 32'd0;
      wb_rdata      <= 32'd0;
      wb_pc4        <= 32'd0;
      wb_committed  <= 1'b0;
      Retire_Count  <= '0;
    end else begin
      if (wr_en)
        Retire_Count <= Retire_Count + RETIRE_W'(1);
      if (Bus.Flush) begin
        wb_valid     <= 1'b0;
        wb_committed <= 1'b0;
      end else if (!Bus.Stall) begin
        wb_valid      <= Bus.Mem_Valid;
        wb_reg_write  <= Bus.Mem_Reg_Write;
        wb_mem_to_reg <= Bus.Mem_Mem_To_Reg;
        wb_link       <= Bus.Mem_Link;
        wb_dest       <= Bus.Mem_Write_Reg;
        wb_alu        <= Bus.Mem_ALU_Result;
        wb_rdata      <= Bus.Mem_Read_Data;
        wb_pc4        <= Bus.Mem_PC_Plus4;
        wb_committed  <= 1'b0;
      end else if (wr_en) begin
        // held instruction has now written once; block repeats while stalled
        wb_committed <= 1'b1;
      end
    end
  end

  always_comb begin
    eff_dest  = wb_link ? 5'd31 : wb_dest;
    eff_dat   = wb_link ? (wb_pc4 + 32'd4) : (wb_mem_to_reg ? wb_rdata : wb_alu);
    dest_live = wb_valid & wb_reg_write & (eff_dest != 5'd0);
    wr_en     = dest_live & ~wb_committed;
  end

  assign Bus.Reg_Write = wr_en;
  assign Bus.Write_Reg = wb_valid ? eff_dest : 5'd0;
  assign Bus.Write_Dat = wb_valid ? eff_dat : 32'd0;

`ifdef WB_FWD_EN
  // committed does not gate forwarding: the value stays current while stalled
  logic hit1;
  logic hit2;
  assign hit1         = dest_live & (eff_dest == Bus.Fwd_Reg1);
  assign hit2         = dest_live & (eff_dest == Bus.Fwd_Reg2);
  assign Bus.Fwd_Hit1 = hit1;
  assign Bus.Fwd_Hit2 = hit2;
  assign Bus.Fwd_Dat1 = hit1 ? eff_dat : 32'd0;
  assign Bus.Fwd_Dat2 = hit2 ? eff_dat : 32'd0;
`else
  assign Bus.Fwd_Hit1 = 1'b0;
  assign Bus.Fwd_Hit2 = 1'b0;
  assign Bus.Fwd_Dat1 = 32'd0;
  assign Bus.Fwd_Dat2 = 32'd0;
`endif

endmodule

// File: tb/tb_mem_wb_writeback.sv
// Self-checking bench for mem_wb_writeback: vector table, corner-case
// sequences and randomized traffic against a behavioural writeback model.
module tb_mem_wb_writeback;
  localparam int RW = 4;

  logic          Clk;
  logic          Rst;
  logic [RW-1:0] Retire_Count;
  int            tests;
  int            fails;

  mem_wb_writeback_if bus ();

  mem_wb_writeback #(.RETIRE_W(RW)) dut (
    .Clk          (Clk),
    .Rst          (Rst),
    .Bus          (bus),
    .Retire_Count (Retire_Count)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

`ifdef WB_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  // model: the instruction sitting in WB and whether it has already written
  typedef struct {
    bit        present;
    bit        writes;
    bit [4:0]  dest;
    bit [31:0] value;
    bit        done;
  } instr_t;

  instr_t  m_wb;
  int      m_cnt;

  function automatic bit m_rw();
    return m_wb.present && m_wb.writes && m_wb.dest != 0 && !m_wb.done;
  endfunction

  function automatic bit m_hit(input bit [4:0] r);
    return FWD && m_wb.present && m_wb.writes && m_wb.dest != 0 && m_wb.dest == r;
  endfunction

  function automatic instr_t decode_mem();
    instr_t t;
    t.present = bus.Mem_Valid;
    t.writes  = bus.Mem_Reg_Write;
    t.dest    = bus.Mem_Link ? 5'd31 : bus.Mem_Write_Reg;
    if (bus.Mem_Link)            t.value = bus.Mem_PC_Plus4 + 32'd4;
    else if (bus.Mem_Mem_To_Reg) t.value = bus.Mem_Read_Data;
    else                         t.value = bus.Mem_ALU_Result;
    t.done = 1'b0;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check_model();
    chk("reg_write", {31'd0, bus.Reg_Write}, {31'd0, m_rw()});
    chk("write_reg", {27'd0, bus.Write_Reg}, m_wb.present ? {27'd0, m_wb.dest} : 32'd0);
    chk("write_dat", bus.Write_Dat, m_wb.present ? m_wb.value : 32'd0);
    chk("fwd_hit1", {31'd0, bus.Fwd_Hit1}, {31'd0, m_hit(bus.Fwd_Reg1)});
    chk("fwd_hit2", {31'd0, bus.Fwd_Hit2}, {31'd0, m_hit(bus.Fwd_Reg2)});
    chk("fwd_dat1", bus.Fwd_Dat1, m_hit(bus.Fwd_Reg1) ? m_wb.value : 32'd0);
    chk("fwd_dat2", bus.Fwd_Dat2, m_hit(bus.Fwd_Reg2) ? m_wb.value : 32'd0);
    chk("retire_count", {28'd0, Retire_Count}, 32'(m_cnt));
  endtask

  // one clock: advance model with the inputs seen at the edge, then compare
  task automatic cyc();
    bit wrote;
    @(posedge Clk);
    wrote = m_rw();
    if (Rst) begin
      m_wb  = '{default: 0};
      m_cnt = 0;
    end else begin
      if (wrote) m_cnt = (m_cnt + 1) % (1 << RW);
      if (bus.Flush)       m_wb = '{default: 0};
      else if (!bus.Stall) m_wb = decode_mem();
      else if (wrote)      m_wb.done = 1'b1;
    end
    #1;
    check_model();
  endtask

  task automatic set_mem(input bit v, input bit rw, input bit m2r, input bit lnk,
                         input bit [4:0] d, input bit [31:0] alu,
                         input bit [31:0] rd, input bit [31:0] pc4);
    bus.Mem_Valid = v; bus.Mem_Reg_Write = rw; bus.Mem_Mem_To_Reg = m2r;
    bus.Mem_Link = lnk; bus.Mem_Write_Reg = d; bus.Mem_ALU_Result = alu;
    bus.Mem_Read_Data = rd; bus.Mem_PC_Plus4 = pc4;
  endtask

  typedef struct {
    bit        v, rw, m2r, lnk;
    bit [4:0]  d;
    bit [31:0] alu, rd, pc4;
    bit [4:0]  fr1, fr2;
    bit        e_rw;
    bit [4:0]  e_reg;
    bit [31:0] e_dat;
    bit        e_hit1, e_hit2;
  } vec_t;

  vec_t vecs[8];
  int   saved;

  initial begin
    tests = 0; fails = 0;
    m_wb = '{default: 0}; m_cnt = 0;
    vecs[0] = '{1,1,0,0, 5'd8,  32'h1234, 32'h0,        32'h0,        5'd8,  5'd3,  1, 5'd8,  32'h1234,     1, 0};
    vecs[1] = '{1,1,1,0, 5'd12, 32'h77,   32'hDEADBEEF, 32'h0,        5'd12, 5'd12, 1, 5'd12, 32'hDEADBEEF, 1, 1};
    vecs[2] = '{1,1,1,1, 5'd5,  32'h1,    32'h2,        32'h400,      5'd5,  5'd31, 1, 5'd31, 32'h404,      0, 1};
    vecs[3] = '{1,1,0,0, 5'd0,  32'h5,    32'h0,        32'h0,        5'd0,  5'd0,  0, 5'd0,  32'h5,        0, 0};
    vecs[4] = '{1,0,0,0, 5'd4,  32'h99,   32'h0,        32'h0,        5'd4,  5'd4,  0, 5'd4,  32'h99,       0, 0};
    vecs[5] = '{0,1,0,0, 5'd7,  32'h55,   32'h0,        32'h0,        5'd7,  5'd7,  0, 5'd0,  32'h0,        0, 0};
    vecs[6] = '{1,1,0,1, 5'd0,  32'h3,    32'h0,        32'hFFFFFFFC, 5'd31, 5'd0,  1, 5'd31, 32'h0,        1, 0};
    vecs[7] = '{1,1,0,0, 5'd4,  32'h44,   32'h0,        32'h0,        5'd2,  5'd4,  1, 5'd4,  32'h44,       0, 1};

    Rst = 1'b1; bus.Stall = 0; bus.Flush = 0; bus.Fwd_Reg1 = 0; bus.Fwd_Reg2 = 0;
    set_mem(1, 1, 0, 0, 5'd3, 32'hAA, 32'h0, 32'h0);
    cyc(); cyc();
    chk("reset_reg_write", {31'd0, bus.Reg_Write}, 32'd0);
    chk("reset_write_dat", bus.Write_Dat, 32'd0);
    Rst = 1'b0;

    // vector table: each entry enters WB with no stall/flush
    foreach (vecs[i]) begin
      set_mem(vecs[i].v, vecs[i].rw, vecs[i].m2r, vecs[i].lnk, vecs[i].d,
              vecs[i].alu, vecs[i].rd, vecs[i].pc4);
      bus.Fwd_Reg1 = vecs[i].fr1; bus.Fwd_Reg2 = vecs[i].fr2;
      cyc();
      chk($sformatf("vec%0d_rw", i), {31'd0, bus.Reg_Write}, {31'd0, vecs[i].e_rw});
      chk($sformatf("vec%0d_reg", i), {27'd0, bus.Write_Reg}, {27'd0, vecs[i].e_reg});
      chk($sformatf("vec%0d_dat", i), bus.Write_Dat, vecs[i].e_dat);
      chk($sformatf("vec%0d_hit1", i), {31'd0, bus.Fwd_Hit1}, {31'd0, FWD & vecs[i].e_hit1});
      chk($sformatf("vec%0d_hit2", i), {31'd0, bus.Fwd_Hit2}, {31'd0, FWD & vecs[i].e_hit2});
      chk($sformatf("vec%0d_dat2", i), bus.Fwd_Dat2,
          (FWD & vecs[i].e_hit2) ? vecs[i].e_dat : 32'd0);
      if (i == 0) begin
        cyc();
        chk("first_retire", {28'd0, Retire_Count}, 32'd1);
      end
    end

    // stall three cycles on dest 9: one write, hit held throughout
    set_mem(1, 1, 0, 0, 5'd9, 32'h900, 32'h0, 32'h0);
    bus.Fwd_Reg1 = 5'd9;
    cyc();
    saved = int'(Retire_Count);
    chk("stall_first_rw", {31'd0, bus.Reg_Write}, 32'd1);
    bus.Stall = 1;
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk("stall_hold_rw", {31'd0, bus.Reg_Write}, 32'd0);
      chk("stall_hold_hit1", {31'd0, bus.Fwd_Hit1}, {31'd0, FWD});
    end
    chk("stall_count", {28'd0, Retire_Count}, 32'((saved + 1) % (1 << RW)));
    bus.Stall = 0;

    // flush with a valid MEM instruction
    bus.Flush = 1;
    set_mem(1, 1, 0, 0, 5'd6, 32'h66, 32'h0, 32'h0);
    cyc();
    chk("flush_rw", {31'd0, bus.Reg_Write}, 32'd0);
    chk("flush_reg", {27'd0, bus.Write_Reg}, 32'd0);
    bus.Flush = 0;

    // flush while stalled, uncommitted: write still happens this cycle
    set_mem(1, 1, 0, 0, 5'd10, 32'hA0, 32'h0, 32'h0);
    cyc();
    saved = int'(Retire_Count);
    bus.Stall = 1; bus.Flush = 1;
    #1;
    chk("flush_stall_rw_now", {31'd0, bus.Reg_Write}, 32'd1);
    cyc();
    chk("flush_stall_after", {31'd0, bus.Reg_Write}, 32'd0);
    chk("flush_stall_count", {28'd0, Retire_Count}, 32'((saved + 1) % (1 << RW)));
    bus.Flush = 0;

    // reset mid-stall discards the held instruction
    bus.Stall = 0;
    set_mem(1, 1, 0, 0, 5'd11, 32'hB0, 32'h0, 32'h0);
    cyc();
    bus.Stall = 1;
    cyc();
    Rst = 1;
    cyc();
    chk("rst_stall_rw", {31'd0, bus.Reg_Write}, 32'd0);
    chk("rst_stall_reg", {27'd0, bus.Write_Reg}, 32'd0);
    chk("rst_stall_dat", bus.Write_Dat, 32'd0);
    chk("rst_stall_count", {28'd0, Retire_Count}, 32'd0);
    Rst = 0; bus.Stall = 0;

    // randomized traffic, small register range to provoke matches
    for (int n = 0; n < 500; n++) begin
      Rst       = ($urandom_range(0, 60) == 0);
      bus.Stall = ($urandom_range(0, 3) == 0);
      bus.Flush = ($urandom_range(0, 7) == 0);
      set_mem($urandom_range(0, 5) != 0, $urandom_range(0, 4) != 0,
              $urandom_range(0, 1) == 1, $urandom_range(0, 7) == 0,
              ($urandom_range(0, 9) == 0) ? 5'd31 : 5'($urandom_range(0, 7)),
              $urandom, $urandom,
              ($urandom_range(0, 9) == 0) ? 32'hFFFFFFFC : $urandom);
      bus.Fwd_Reg1 = ($urandom_range(0, 5) == 0) ? 5'd31 : 5'($urandom_range(0, 7));
      bus.Fwd_Reg2 = ($urandom_range(0, 5) == 0) ? 5'd31 : 5'($urandom_range(0, 7));
      cyc();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/mem_wb_writeback.md
# mem_wb_writeback

MEM/WB pipeline register and writeback driver for the pipelined MIPS core. Captures the retiring instruction's result from the MEM stage, selects ALU result, load data or link address, and drives the register file write port (Reg_Write, Write_Reg, Write_Dat) sampled on the posedge of Clk. Also provides WB→EX forwarding of the in-flight writeback value and a retired-write counter.

## Interface
- RETIRE_W, 32, width of retired-write counter
- Clk  in  1  core clock; all state updates on posedge
- Rst  in  1  synchronous, active-high reset
- Stall  in  1  hold WB register contents
- Flush  in  1  replace incoming instruction with bubble
- Mem_Valid  in  1  MEM stage holds a real instruction
- Mem_Reg_Write  in  1  instruction writes a register
- Mem_Mem_To_Reg  in  1  1 = write load data, 0 = ALU result
- Mem_Link  in  1  jal/jalr: write link address
- Mem_Write_Reg  in  5  destination register
- Mem_ALU_Result  in  32  ALU result
- Mem_Read_Data  in  32  data memory load data
- Mem_PC_Plus4  in  32  PC+4 of the instruction
- Reg_Write  out  1  register file write enable
- Write_Reg  out  5  register file write address
- Write_Dat  out  32  register file write data
- Fwd_Reg1, Fwd_Reg2  in  5 each  EX-stage source register numbers
- Fwd_Hit1, Fwd_Hit2  out  1 each  WB result matches source
- Fwd_Dat1, Fwd_Dat2  out  32 each  forwarded data
- Retire_Count  out  RETIRE_W  number of committed register writes

## Operation
- WB register fields: valid, reg_write, mem_to_reg, link, dest, alu, rdata, pc4, committed.
- Capture (posedge, Rst=0): Flush → valid=0; else !Stall → load all fields from Mem_*, committed=0; else (Stall) hold fields, committed set to 1 if a write was issued this cycle.
- Flush has priority over Stall.
- Effective dest: link ? 5'd31 : dest. Effective data: link ? pc4+4 : (mem_to_reg ? rdata : alu); addition modulo 2^32.
- Reg_Write = valid & reg_write & !committed & (effective dest != 0). Writes to $0 always suppressed.
- Write_Reg/Write_Dat combinational from WB fields (effective dest/data) whenever valid; 0 when !valid.
- A stalled instruction writes exactly once (first cycle); subsequent stall cycles have Reg_Write=0.
- Retire_Count increments by 1 on each posedge where Reg_Write=1; wraps at 2^RETIRE_W to 0.
- Forwarding: Fwd_HitN = valid & reg_write & (effective dest != 0) & (effective dest == Fwd_RegN); Fwd_DatN = Write_Dat when hit, else 0. Committed does not suppress hit (value stays current while stalled).

## Timing
- Reset: all WB fields 0 → Reg_Write=0, Write_Reg=0, Write_Dat=0, Fwd_Hit*=0, Fwd_Dat*=0, Retire_Count=0.
- Latency: MEM inputs at posedge N appear on write port during cycle N→N+1; register file commits at posedge N+1; register file negedge read in that same cycle returns new value.
- Forward outputs combinational from WB register and Fwd_Reg*; valid same cycle.
- Rst mid-stall: state cleared; held instruction discarded, not written.
- Flush while stalled: held instruction dropped at next posedge; if not yet committed it still writes in the current cycle.
- Reg_Write and Flush same cycle: current write proceeds; counter increments.

## Configuration
- WB_FWD_EN defined: forwarding comparators and Fwd_Hit*/Fwd_Dat* logic as above.
- Not defined: Fwd_Hit1/2 tied 0, Fwd_Dat1/2 tied 0, Fwd_Reg* ignored; all other behaviour unchanged.

## Test plan
- ALU write: Mem_Write_Reg=8, ALU=0x1234, Mem_To_Reg=0 → next cycle Reg_Write=1, Write_Reg=8, Write_Dat=0x1234; Retire_Count=1.
- Load and link: Mem_To_Reg=1, Read_Data=0xDEADBEEF → Write_Dat=0xDEADBEEF; Link=1, PC_Plus4=0x400 → Write_Reg=31, Write_Dat=0x404.
- $0 suppression: Reg_Write=1, dest=0, ALU=5 → Reg_Write=0, Fwd_Hit1=0 with Fwd_Reg1=0, counter unchanged.
- Stall 3 cycles on dest=9 → Reg_Write=1 first cycle only, 0 for remaining; Retire_Count +1 total; Fwd_Hit1=1 (Fwd_Reg1=9) all cycles.
- Flush with valid MEM instruction → following cycle Reg_Write=0, Write_Reg=0; Rst asserted mid-stall → all outputs 0 next cycle.
- WB_FWD_EN undefined: dest=4, Fwd_Reg2=4 → Fwd_Hit2=0, Fwd_Dat2=0; defined → Fwd_Hit2=1, Fwd_Dat2=Write_Dat.
